// File: rtl/image_centering.sv
// image_centering
//   Recentres a DIM x DIM binary bitmap so that the centre of its ink bounding
//   box lands on (TARGET_R, TARGET_C). It makes a row-serial bounding-box scan
//   and then a row-serial shift into a work buffer. The finished image is
//   published in one step when done pulses.
//
//   Ports
//     TPU_clk    clock
//     iRst_n     asynchronous active-low reset
//     start      request; sampled only while idle
//     image_in   source bitmap; pixel (r,c) is bit r*DIM+c, 1 = ink
//     image_out  centred bitmap with the same bit mapping
//     busy       high from the cycle after acceptance until done
//     done       one-cycle pulse; image_out and empty are valid
//     empty      the source had no ink; held until the next done
//
//   state   | meaning
//   S_IDLE  | waiting for start; latches image_in on acceptance
//   S_SCAN  | one source row per clock: row bbox and column OR-mask
//   S_CALC  | column bbox and centre offsets dr/dc; empty images finish here
//   S_SHIFT | one destination row per clock into the work buffer
module image_centering #(
    parameter int DIM      = 32,
    parameter int TARGET_R = 15,
    parameter int TARGET_C = 15
) (
    input  logic                 TPU_clk,
    input  logic                 iRst_n,
    input  logic                 start,
    input  logic [DIM*DIM-1:0]   image_in,
    output logic [DIM*DIM-1:0]   image_out,
    output logic                 busy,
    output logic                 done,
    output logic                 empty
);

    localparam int RW = $clog2(DIM);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_CALC  = 2'd2;
    localparam logic [1:0] S_SHIFT = 2'd3;

    logic [1:0]             state;
    logic [DIM*DIM-1:0]     src;
    // Rows 0..DIM-2 of the result. Rows are shifted in from the top. The last
    // row goes straight to image_out, so it is never stored here.
    logic [DIM*(DIM-1)-1:0] work;
    logic [RW-1:0]          row_cnt;
    logic [RW-1:0]          min_r;
    logic [RW-1:0]          max_r;
    logic [DIM-1:0]         col_mask;
    logic signed [6:0]      dr;
    logic signed [6:0]      dc;

    logic                   last_row;
    logic [DIM-1:0]         scan_row;
    logic [RW-1:0]          min_c;
    logic [RW-1:0]          max_c;
    logic [RW:0]            cr;
    logic [RW:0]            cc;
    logic signed [6:0]      dr_calc;
    logic signed [6:0]      dc_calc;
    logic signed [7:0]      src_r;
    logic                   src_ok;
    logic [DIM-1:0]         src_row;
    logic [6:0]             neg_dc;
    logic [DIM-1:0]         shifted_row;

    assign last_row = (row_cnt == RW'(DIM - 1));
    assign scan_row = src[{row_cnt, {RW{1'b0}}} +: DIM];

    always_comb begin
        min_c = '0;
        max_c = '0;
        for (int c = DIM - 1; c >= 0; c--) begin
            if (col_mask[c]) min_c = RW'(c);
        end
        for (int c = 0; c < DIM; c++) begin
            if (col_mask[c]) max_c = RW'(c);
        end
    end

    always_comb begin
        cr      = ({1'b0, min_r} + {1'b0, max_r}) >> 1;
        cc      = ({1'b0, min_c} + {1'b0, max_c}) >> 1;
        dr_calc = 7'(TARGET_R) - {1'b0, cr};
        dc_calc = 7'(TARGET_C) - {1'b0, cc};
    end

    // The source row for destination row_cnt is row_cnt - dr. A signed 8-bit
    // index keeps rows above and below the frame from wrapping.
    always_comb begin
        src_r   = $signed({{(8 - RW){1'b0}}, row_cnt}) - $signed({dr[6], dr});
        src_ok  = (src_r >= 8'sd0) && (src_r < $signed(8'(DIM)));
        src_row = src_ok ? src[{src_r[RW-1:0], {RW{1'b0}}} +: DIM] : '0;
        neg_dc  = -dc;
        // Logical shifts drop ink that moves past either edge.
        shifted_row = dc[6] ? (src_row >> neg_dc) : (src_row << dc);
    end

    always_ff @(posedge TPU_clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state     <= S_IDLE;
            src       <= '0;
            work      <= '0;
            row_cnt   <= '0;
            min_r     <= '0;
            max_r     <= '0;
            col_mask  <= '0;
            dr        <= '0;
            dc        <= '0;
            image_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            empty     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        src      <= image_in;
                        min_r    <= RW'(DIM - 1);
                        max_r    <= '0;
                        col_mask <= '0;
                        row_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (|scan_row) begin
                        if (row_cnt < min_r) min_r <= row_cnt;
                        if (row_cnt > max_r) max_r <= row_cnt;
                    end
                    col_mask <= col_mask | scan_row;
                    row_cnt  <= row_cnt + 1'b1;
                    if (last_row) state <= S_CALC;
                end
                S_CALC: begin
                    row_cnt <= '0;
                    if (col_mask == '0) begin
                        empty     <= 1'b1;
                        image_out <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        dr    <= dr_calc;
                        dc    <= dc_calc;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    work    <= {shifted_row, work[DIM*(DIM-1)-1:DIM]};
                    row_cnt <= row_cnt + 1'b1;
                    if (last_row) begin
                        image_out <= {shifted_row, work};
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        empty     <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_centering.sv
module tb_image_centering;

    localparam int DIM = 32;
    localparam int N   = DIM * DIM;

    logic         TPU_clk = 1'b0;
    logic         iRst_n  = 1'b1;
    logic         start   = 1'b0;
    logic [N-1:0] image_in = '0;
    logic [N-1:0] image_out;
    logic         busy;
    logic         done;
    logic         empty;

    always #5 TPU_clk = ~TPU_clk;

    image_centering #(.DIM(DIM), .TARGET_R(15), .TARGET_C(15)) dut (
        .TPU_clk  (TPU_clk),
        .iRst_n   (iRst_n),
        .start    (start),
        .image_in (image_in),
        .image_out(image_out),
        .busy     (busy),
        .done     (done),
        .empty    (empty)
    );

    typedef struct {
        logic [N-1:0] img;
        logic         emp;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [N-1:0] block(input int r0, input int r1, input int c0, input int c1);
        logic [N-1:0] b = '0;
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                b[r*DIM+c] = 1'b1;
        return b;
    endfunction

    function automatic int diff_row(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int r = 0; r < DIM; r++)
            if (a[r*DIM +: DIM] !== b[r*DIM +: DIM]) return r;
        return 0;
    endfunction

    // Reference: move every ink pixel by (15 - bbox centre), dropping what leaves the frame.
    function automatic exp_t ref_center(input logic [N-1:0] img);
        exp_t x;
        int minr = DIM, maxr = -1, minc = DIM, maxc = -1;
        int dr, dc, tr, tc;
        x.img = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (img[r*DIM+c]) begin
                    if (r < minr) minr = r;
                    if (r > maxr) maxr = r;
                    if (c < minc) minc = c;
                    if (c > maxc) maxc = c;
                end
        if (maxr < 0) begin
            x.emp = 1'b1;
            x.lat = 33;
            return x;
        end
        dr = 15 - (minr + maxr) / 2;
        dc = 15 - (minc + maxc) / 2;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (img[r*DIM+c]) begin
                    tr = r + dr;
                    tc = c + dc;
                    if (tr >= 0 && tr < DIM && tc >= 0 && tc < DIM) x.img[tr*DIM+tc] = 1'b1;
                end
        x.emp = 1'b0;
        x.lat = 65;
        return x;
    endfunction

    // Drives a request that is accepted on the next rising edge and returns
    // 1 time unit after that edge. image_in is then scrambled.
    task automatic start_run(input logic [N-1:0] img, input bit hold);
        @(negedge TPU_clk);
        image_in = img;
        start    = 1'b1;
        @(posedge TPU_clk);
        #1;
        if (!hold) start = 1'b0;
        image_in = {DIM{$urandom()}};
    endtask

    // Counts edges from acceptance to done (bounded to 300), busy-high
    // samples, and image_out changes seen before done.
    task automatic collect(output int lat, output int bcnt, output int chg);
        logic [N-1:0] prev;
        prev = image_out;
        lat  = 0;
        bcnt = (busy === 1'b1) ? 1 : 0;
        chg  = 0;
        while (done !== 1'b1 && lat < 300) begin
            @(posedge TPU_clk);
            #1;
            lat++;
            if (done !== 1'b1) begin
                if (busy === 1'b1) bcnt++;
                if (image_out !== prev) chg++;
            end
        end
    endtask

    task automatic test_reset;
        image_in = {DIM{$urandom()}};
        #2 iRst_n = 1'b0;
        repeat (2) @(posedge TPU_clk);
        #1;
        n_checks++; if (image_out !== '0) begin n_fail++; $display("FAIL reset_image: got %0d ones, expected 0", $countones(image_out)); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL reset_empty: got %b expected 0", empty); end
        @(negedge TPU_clk);
        iRst_n = 1'b1;
    endtask

    task automatic test_single_pixel;
        logic [N-1:0] img;
        exp_t e;
        int lat, bcnt, chg, r;
        img = '0;
        img[0] = 1'b1;
        e.img = '0;
        e.img[15*DIM+15] = 1'b1;
        e.emp = 1'b0;
        e.lat = 65;
        sb.push_back(e);
        start_run(img, 0);
        collect(lat, bcnt, chg);
        e = sb.pop_front();
        r = diff_row(image_out, e.img);
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL single_image: row %0d got %h expected %h", r, image_out[r*DIM +: DIM], e.img[r*DIM +: DIM]); end
        n_checks++; if (empty !== e.emp) begin n_fail++; $display("FAIL single_empty: got %b expected %b", empty, e.emp); end
        n_checks++; if (bcnt !== 65) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected 65", bcnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_at_done: got %b expected 0", busy); end
        @(posedge TPU_clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b expected 0", done); end
        n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL single_image_hold: got %0d ones expected %0d", $countones(image_out), $countones(e.img)); end
    endtask

    task automatic test_empty;
        exp_t e;
        int lat, bcnt, chg;
        e.img = '0;
        e.emp = 1'b1;
        e.lat = 33;
        sb.push_back(e);
        start_run('0, 0);
        collect(lat, bcnt, chg);
        e = sb.pop_front();
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL empty_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL empty_image: got %0d ones expected 0", $countones(image_out)); end
        n_checks++; if (empty !== e.emp) begin n_fail++; $display("FAIL empty_flag: got %b expected %b", empty, e.emp); end
        n_checks++; if (chg !== 0) begin n_fail++; $display("FAIL empty_no_partial: got %0d changes expected 0", chg); end
        n_checks++; if (bcnt !== 33) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d expected 33", bcnt); end
        repeat (3) @(posedge TPU_clk);
        #1;
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL empty_hold: got %b expected 1", empty); end
    endtask

    // Each table row is a source block and the block expected after centring.
    task automatic test_blocks;
        int src_b[3][4] = '{'{14, 16, 14, 16}, '{0, 31, 0, 31}, '{28, 31, 0, 3}};
        int dst_b[3][4] = '{'{14, 16, 14, 16}, '{0, 31, 0, 31}, '{14, 17, 14, 17}};
        exp_t e;
        int lat, bcnt, chg, r;
        for (int k = 0; k < 3; k++) begin
            e.img = block(dst_b[k][0], dst_b[k][1], dst_b[k][2], dst_b[k][3]);
            e.emp = 1'b0;
            e.lat = 65;
            sb.push_back(e);
            start_run(block(src_b[k][0], src_b[k][1], src_b[k][2], src_b[k][3]), 0);
            collect(lat, bcnt, chg);
            e = sb.pop_front();
            r = diff_row(image_out, e.img);
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL block%0d_latency: got %0d expected %0d", k, lat, e.lat); end
            n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL block%0d_image: row %0d got %h expected %h", k, r, image_out[r*DIM +: DIM], e.img[r*DIM +: DIM]); end
            n_checks++; if (empty !== e.emp) begin n_fail++; $display("FAIL block%0d_empty: got %b expected %b", k, empty, e.emp); end
            n_checks++; if (chg !== 0) begin n_fail++; $display("FAIL block%0d_no_partial: got %0d changes expected 0", k, chg); end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] img;
        exp_t e;
        int lat, bcnt, chg, r;
        for (int k = 0; k < 4; k++) begin
            img = {DIM{$urandom()}} & {DIM{$urandom()}} & {DIM{$urandom()}};
            img = img & block($urandom_range(0, 12), $urandom_range(13, 31), $urandom_range(0, 12), $urandom_range(13, 31));
            sb.push_back(ref_center(img));
            start_run(img, 0);
            collect(lat, bcnt, chg);
            e = sb.pop_front();
            r = diff_row(image_out, e.img);
            n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", k, lat, e.lat); end
            n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL rand%0d_image: row %0d got %h expected %h", k, r, image_out[r*DIM +: DIM], e.img[r*DIM +: DIM]); end
            n_checks++; if (empty !== e.emp) begin n_fail++; $display("FAIL rand%0d_empty: got %b expected %b", k, empty, e.emp); end
        end
    endtask

    task automatic test_back_to_back;
        logic [N-1:0] img1, img2;
        exp_t e;
        int lat, bcnt, chg, r;
        img1 = block(3, 6, 20, 27);
        img2 = block(22, 30, 1, 9) & {DIM{$urandom()}};
        img2[22*DIM+1] = 1'b1;
        sb.push_back(ref_center(img1));
        sb.push_back(ref_center(img2));
        start_run(img1, 1);
        collect(lat, bcnt, chg);
        e = sb.pop_front();
        r = diff_row(image_out, e.img);
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL b2b_first_image: row %0d got %h expected %h", r, image_out[r*DIM +: DIM], e.img[r*DIM +: DIM]); end
        image_in = img2;
        @(posedge TPU_clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept: busy got %b expected 1", busy); end
        start = 1'b0;
        image_in = {DIM{$urandom()}};
        collect(lat, bcnt, chg);
        e = sb.pop_front();
        r = diff_row(image_out, e.img);
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL b2b_second_image: row %0d got %h expected %h", r, image_out[r*DIM +: DIM], e.img[r*DIM +: DIM]); end
        n_checks++; if ($countones(image_out) !== $countones(img2)) begin n_fail++; $display("FAIL b2b_pixel_count: got %0d expected %0d", $countones(image_out), $countones(img2)); end
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] img;
        exp_t e;
        int lat, bcnt, chg, r;
        start_run(block(2, 5, 2, 5), 0);
        repeat (40) @(posedge TPU_clk);
        #1;
        iRst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_checks++; if (image_out !== '0) begin n_fail++; $display("FAIL midrst_image: got %0d ones expected 0", $countones(image_out)); end
        @(negedge TPU_clk);
        iRst_n = 1'b1;
        img = block(20, 22, 5, 9);
        sb.push_back(ref_center(img));
        start_run(img, 0);
        collect(lat, bcnt, chg);
        e = sb.pop_front();
        r = diff_row(image_out, e.img);
        n_checks++; if (lat !== e.lat) begin n_fail++; $display("FAIL midrst_rerun_latency: got %0d expected %0d", lat, e.lat); end
        n_checks++; if (image_out !== e.img) begin n_fail++; $display("FAIL midrst_rerun_image: row %0d got %h expected %h", r, image_out[r*DIM +: DIM], e.img[r*DIM +: DIM]); end
        n_checks++; if (empty !== e.emp) begin n_fail++; $display("FAIL midrst_rerun_empty: got %b expected %b", empty, e.emp); end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_empty();
        test_blocks();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
